alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 16 bits and the op width at 4 bits.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  2  bit i: requester i presents an operation.
REQ-005 req_ready  out  2  bit i: operation of requester i accepted this cycle.
REQ-006 req0_op/req1_op  in  4 each  ALU opcode per requester.
REQ-007 req0_a/req0_b/req1_a/req1_b  in  16 each  operands per requester.
REQ-008 rsp_valid  out  2  bit i: result for requester i is available.
REQ-009 rsp_ready  in  2  bit i: requester i takes the result.
REQ-010 rsp_res  out  16  result of the completed operation.
REQ-011 rsp_szcv  out  4  {S,Z,C,V} flags of the completed operation.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL share one ALU instance between two requesters using the FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-014 In IDLE with any req_valid set: grant one port, assert req_ready for that port only (combinational, same cycle), latch op/a/b, and go to EXEC.
REQ-015 In EXEC: present the latched operands to the ALU and register res/szcv; go to RESP unconditionally.
REQ-016 In RESP: hold rsp_valid[grant] and stable rsp_res/rsp_szcv until rsp_ready[grant]=1, then go to IDLE.
REQ-017 Latency: an accept at edge N makes rsp_valid high from edge N+2; peak throughput is one operation per 3 cycles.
REQ-018 Opcode set: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 CMP (=SUB), 0110 MOV b, 1000 SLL, 1001 ROL, 1010 SRL, 1011 SRA; shift amount is b[3:0].
REQ-019 Flag rules: S=res[15]; Z=(res==0); C=bit 16 of the ADD/SUB result or the last bit shifted out; V=signed overflow for ADD/SUB only, otherwise 0.
REQ-020 Any undefined opcode SHALL give res=0x0000, szcv=4'b0100 and still complete through RESP.
REQ-021 req_ready=0 and all req_valid are ignored outside IDLE; rsp_ready is ignored outside RESP, and rsp_ready on the non-granted port is ignored.
REQ-022 rsp_valid SHALL never be high on both bits at once.

Reset
REQ-023 rst_n low SHALL force, from any state including mid-EXEC/RESP, the following outputs: state=IDLE, req_ready=0, rsp_valid=0, rsp_res=0x0000, rsp_szcv=0000, busy=0.
REQ-024 The last-grant pointer SHALL reset to 1, so port 0 wins the first tie; any in-flight operation is discarded.

Configuration
REQ-025 Macro ALU_ARB_RR_EN defined: on a tie, grant the port not granted last; the pointer updates on each accept.
REQ-026 Macro ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; the pointer logic is absent.

Structure
REQ-027 The opcode constants, the FSM state encoding and the szcv bit indices SHALL live in the shared package alu_pkg.
REQ-028 The combinational datapath SHALL be the sub-module alu_core (a, b, op -> res, szcv), instantiated exactly once.

Verification
REQ-029 Port 0 ADD a=0x7FFF b=0x0001 -> req_ready[0] in the accept cycle; 2 edges later rsp_valid[0]=1, rsp_res=0x8000, rsp_szcv=1001.
REQ-030 Port 1 SUB a=0x0000 b=0x0001 -> rsp_res=0xFFFF, rsp_szcv=1010.
REQ-031 Both ports valid continuously with ALU_ARB_RR_EN defined -> grant order 0,1,0,1; with it undefined -> 0,0,0,0.
REQ-032 rsp_ready low for 5 cycles in RESP -> rsp_valid and data stay stable, busy=1, req_ready stays 00; accept resumes one cycle after the handshake.
REQ-033 Opcode 0111 -> rsp_res=0x0000, rsp_szcv=0100.
REQ-034 rst_n asserted during EXEC -> all outputs are at reset values immediately; after release the next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: widths, opcodes, FSM encoding,
// flag bit positions and the latched request record.
// Latency: n/a (package). Backpressure: n/a.
package alu_pkg;

   localparam int DATA_W  = 16;
   localparam int OP_W    = 4;
   localparam int SZCV_W  = 4;
   localparam int N_PORTS = 2;

   // Opcode map; every other encoding is treated as undefined.
   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
   localparam logic [OP_W-1:0] OP_CMP = 4'b0101;
   localparam logic [OP_W-1:0] OP_MOV = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLL = 4'b1000;
   localparam logic [OP_W-1:0] OP_ROL = 4'b1001;
   localparam logic [OP_W-1:0] OP_SRL = 4'b1010;
   localparam logic [OP_W-1:0] OP_SRA = 4'b1011;

   // Bit positions inside the {S,Z,C,V} flag vector.
   localparam int SZCV_S = 3;
   localparam int SZCV_Z = 2;
   localparam int SZCV_C = 1;
   localparam int SZCV_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } req_t;

   // Port index -> one-hot handshake vector.
   function automatic logic [N_PORTS-1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester-side request and response handshakes of the ALU arbiter.
// Latency: n/a (wires only). Backpressure: req_valid/req_ready and rsp_valid/rsp_ready pairs.
// Ports: master = requester side (drives requests, takes results); slave = arbiter side.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic [N_PORTS-1:0] req_valid;
   logic [N_PORTS-1:0] req_ready;
   logic [OP_W-1:0]    req0_op;
   logic [DATA_W-1:0]  req0_a;
   logic [DATA_W-1:0]  req0_b;
   logic [OP_W-1:0]    req1_op;
   logic [DATA_W-1:0]  req1_a;
   logic [DATA_W-1:0]  req1_b;
   logic [N_PORTS-1:0] rsp_valid;
   logic [N_PORTS-1:0] rsp_ready;
   logic [DATA_W-1:0]  rsp_res;
   logic [SZCV_W-1:0]  rsp_szcv;
   logic               busy;

   modport master (
      output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_szcv, busy
   );

   modport slave (
      input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_szcv, busy
   );

endinterface

// File: rtl/alu_core.sv
// Combinational 16-bit ALU: arithmetic, logic, shifts/rotate with {S,Z,C,V} flags.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Ports: op (4b opcode), a/b (16b operands, shift amount b[3:0]) -> res (16b), szcv (4b flags).
module alu_core
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res,
   output logic [SZCV_W-1:0] szcv
);

   logic [3:0]              amt;
   logic [DATA_W:0]         sum;
   logic [DATA_W:0]         diff;
   logic [DATA_W:0]         sh_l;   // bit 16 = last bit shifted out
   logic [DATA_W:0]         sh_r;   // bit 0  = last bit shifted out
   logic signed [DATA_W:0]  sh_a;   // bit 0  = last bit shifted out
   logic [DATA_W-1:0]       rot;
   logic                    carry;
   logic                    ovf;

   assign amt = b[3:0];

   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      diff  = {1'b0, a} - {1'b0, b};
      // One extra bit on the far side of each shifter captures the carry-out.
      sh_l  = {1'b0, a} << amt;
      sh_r  = {a, 1'b0} >> amt;
      sh_a  = $signed({a, 1'b0}) >>> amt;
      // A right shift by 16 (amt=0) yields 0, so rotate-by-0 returns a.
      rot   = (a << amt) | (a >> (5'd16 - {1'b0, amt}));

      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            res   = sum[DATA_W-1:0];
            carry = sum[DATA_W];
            ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
         end
         OP_SUB, OP_CMP: begin
            res   = diff[DATA_W-1:0];
            carry = diff[DATA_W];
            ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_MOV: res = b;
         OP_SLL: begin
            res   = sh_l[DATA_W-1:0];
            carry = sh_l[DATA_W];
         end
         OP_ROL: begin
            res   = rot;
            // The bit rotated out last lands in res[0]; nothing moves for amt=0.
            carry = (|amt) & rot[0];
         end
         OP_SRL: begin
            res   = sh_r[DATA_W:1];
            carry = sh_r[0];
         end
         OP_SRA: begin
            res   = sh_a[DATA_W:1];
            carry = sh_a[0];
         end
         // Undefined opcode: res stays 0, so the flags come out as Z only.
         default: res = '0;
      endcase

      szcv         = '0;
      szcv[SZCV_S] = res[DATA_W-1];
      szcv[SZCV_Z] = (res == '0);
      szcv[SZCV_C] = carry;
      szcv[SZCV_V] = ovf;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters through an IDLE -> EXEC -> RESP FSM.
// Latency: request accepted in the cycle starting at edge N -> rsp_valid from edge N+2; max one op per 3 cycles.
// Backpressure: req_ready only in IDLE; result held stable in RESP until rsp_ready of the granted port.
// Ports: clk, rst_n (async active-low); bus (alu_arbiter_if.slave): req_valid/req_ready[1:0],
//        req0_/req1_ op,a,b; rsp_valid/rsp_ready[1:0], rsp_res, rsp_szcv; busy.
// Config: define ALU_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   state_e             state;
   state_e             state_nxt;
   req_t               req_in;
   req_t               req_q;
   logic               grant_sel;
   logic               grant_q;
   logic               accept;
   logic               rsp_hs;
   logic [DATA_W-1:0]  alu_res;
   logic [SZCV_W-1:0]  alu_szcv;
   logic [DATA_W-1:0]  res_q;
   logic [SZCV_W-1:0]  szcv_q;

   // ---------------------------------------------------------------- grant
`ifdef ALU_ARB_RR_EN
   logic last_q;   // port granted most recently; reset to 1 so port 0 wins the first tie

   always_comb begin
      if (bus.req_valid == 2'b11) begin
         grant_sel = ~last_q;
      end else begin
         grant_sel = ~bus.req_valid[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (accept) begin
         last_q <= grant_sel;
      end
   end
`else
   assign grant_sel = ~bus.req_valid[0];
`endif

   always_comb begin
      if (grant_sel) begin
         req_in = '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b};
      end else begin
         req_in = '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};
      end
   end

   // rst_n is folded in so req_ready drops the moment reset is applied.
   assign accept = rst_n && (state == ST_IDLE) && (|bus.req_valid);
   assign rsp_hs = (state == ST_RESP) && bus.rsp_ready[grant_q];

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: if (rsp_hs) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs
   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.busy      = (state != ST_IDLE);
      if (accept) begin
         bus.req_ready = port_onehot(grant_sel);
      end
      if (state == ST_RESP) begin
         bus.rsp_valid = port_onehot(grant_q);
      end
   end

   assign bus.rsp_res  = res_q;
   assign bus.rsp_szcv = szcv_q;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         grant_q <= 1'b0;
         res_q   <= '0;
         szcv_q  <= '0;
      end else begin
         if (accept) begin
            req_q   <= req_in;
            grant_q <= grant_sel;
         end
         if (state == ST_EXEC) begin
            res_q  <= alu_res;
            szcv_q <= alu_szcv;
         end
      end
   end

   alu_core u_alu (
      .op   (req_q.op),
      .a    (req_q.a),
      .b    (req_q.b),
      .res  (alu_res),
      .szcv (alu_szcv)
   );

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors, per-port request queues, scoreboard + monitor.
// Latency: checks rsp_valid appears two edges after the accept-cycle edge.
// Backpressure: monitor can hold rsp_ready low for a programmable number of RESP cycles.
module tb_alu_arbiter;

   typedef struct packed {
      logic        p;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  szcv;
      logic        drop;     // in-flight op that a reset will discard
      logic        resume;   // accept must land right after the previous handshake
   } vec_t;

   typedef struct packed {
      vec_t v;
      int   acc;
   } sb_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   stall_n = 0;
   int   hs_edge = 0;

   vec_t pq0[$];
   vec_t pq1[$];
   sb_t  sb[$];
   int   grant_log[$];

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic vec_t mk(input logic p, input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] res, input logic [3:0] szcv);
      vec_t v;
      v      = '0;
      v.p    = p;
      v.op   = op;
      v.a    = a;
      v.b    = b;
      v.res  = res;
      v.szcv = szcv;
      return v;
   endfunction

   function automatic void issue(input vec_t v);
      if (v.p) pq1.push_back(v);
      else     pq0.push_back(v);
   endfunction

   // ---------------------------------------------------------------- driver
   initial begin
      vec_t v;
      bus.req_valid = 2'b00;
      bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
      forever begin
         @(negedge clk);
         bus.req_valid = {pq1.size() != 0, pq0.size() != 0};
         if (pq0.size() != 0) begin
            bus.req0_op = pq0[0].op; bus.req0_a = pq0[0].a; bus.req0_b = pq0[0].b;
         end
         if (pq1.size() != 0) begin
            bus.req1_op = pq1[0].op; bus.req1_a = pq1[0].a; bus.req1_b = pq1[0].b;
         end
         #1;
         if (bus.req_ready != 2'b00) begin
            chk("req_ready_onehot",
                32'((bus.req_ready == 2'b01 && bus.req_valid[0]) ||
                    (bus.req_ready == 2'b10 && bus.req_valid[1])), 32'd1);
            if (bus.req_ready[0]) v = pq0.pop_front();
            else                  v = pq1.pop_front();
            grant_log.push_back(int'(bus.req_ready[1]));
            if (v.resume) chk("resume_after_hs", cyc, hs_edge);
            if (!v.drop) sb.push_back('{v: v, acc: cyc});
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   bit          seen = 1'b0;
   int          hold = 0;
   logic [1:0]  sv_vld;
   logic [15:0] sv_res;
   logic [3:0]  sv_szcv;

   initial begin
      sb_t e;
      bus.rsp_ready = 2'b11;   // outside RESP it must be ignored
      forever begin
         @(negedge clk);
         #2;
         if (bus.rsp_valid != 2'b00) begin
            if (!seen) begin
               chk("rsp_valid_onehot", 32'(bus.rsp_valid == 2'b01 || bus.rsp_valid == 2'b10), 32'd1);
               if (sb.size() == 0) begin
                  chk("rsp_unexpected", bus.rsp_valid, 2'b00);
               end else begin
                  e = sb[0];
                  chk("rsp_port",    bus.rsp_valid, e.v.p ? 2'b10 : 2'b01);
                  chk("rsp_res",     bus.rsp_res,   e.v.res);
                  chk("rsp_szcv",    bus.rsp_szcv,  e.v.szcv);
                  chk("rsp_latency", cyc,           e.acc + 2);
               end
               seen    = 1'b1;
               hold    = 0;
               sv_vld  = bus.rsp_valid;
               sv_res  = bus.rsp_res;
               sv_szcv = bus.rsp_szcv;
            end else begin
               chk("stall_rsp_valid", bus.rsp_valid, sv_vld);
               chk("stall_rsp_res",   bus.rsp_res,   sv_res);
               chk("stall_rsp_szcv",  bus.rsp_szcv,  sv_szcv);
               chk("stall_busy",      bus.busy,      1'b1);
               chk("stall_req_ready", bus.req_ready, 2'b00);
            end
            if (hold >= stall_n) begin
               bus.rsp_ready = bus.rsp_valid;
               hs_edge = cyc + 1;
               if (sb.size() != 0) e = sb.pop_front();
               seen = 1'b0;
            end else begin
               bus.rsp_ready = ~bus.rsp_valid;   // only the non-granted port says ready
               hold++;
            end
         end else begin
            bus.rsp_ready = 2'b11;
         end
      end
   end

   // ---------------------------------------------------------------- sequencer
   task automatic wait_drain(input string name);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk);
         #3;
         n++;
         done = (pq0.size() == 0) && (pq1.size() == 0) && (sb.size() == 0) && !bus.busy;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s: drain timeout, pending q0=%0d q1=%0d sb=%0d busy=%0b required all idle",
                  name, pq0.size(), pq1.size(), sb.size(), bus.busy);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 2'b00);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
      chk({tag, "_rsp_res"},   bus.rsp_res,   16'h0000);
      chk({tag, "_rsp_szcv"},  bus.rsp_szcv,  4'b0000);
      chk({tag, "_busy"},      bus.busy,      1'b0);
   endtask

   initial begin
      vec_t v;
      int   start;
      int   n;
      int   exp_g [4];

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Signed overflow on ADD, then borrow on SUB from the other port.
      issue(mk(1'b0, 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001));
      wait_drain("add_ovf");
      issue(mk(1'b1, 4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010));
      wait_drain("sub_borrow");

      // Opcode sweep, both ports loaded at once.
      issue(mk(1'b0, 4'b0010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000));
      issue(mk(1'b1, 4'b0011, 16'h1200, 16'h0034, 16'h1234, 4'b0000));
      issue(mk(1'b0, 4'b0100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100));
      issue(mk(1'b1, 4'b0101, 16'h0005, 16'h0005, 16'h0000, 4'b0100));
      issue(mk(1'b0, 4'b0110, 16'h1111, 16'h8001, 16'h8001, 4'b1000));
      issue(mk(1'b1, 4'b1000, 16'h8001, 16'h0001, 16'h0002, 4'b0010));
      issue(mk(1'b0, 4'b1001, 16'h8001, 16'h0001, 16'h0003, 4'b0010));
      issue(mk(1'b1, 4'b1010, 16'h0003, 16'h0001, 16'h0001, 4'b0010));
      issue(mk(1'b0, 4'b1011, 16'h8000, 16'h0004, 16'hF800, 4'b1000));
      issue(mk(1'b1, 4'b1000, 16'h1234, 16'h0000, 16'h1234, 4'b0000));
      issue(mk(1'b0, 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110));
      issue(mk(1'b1, 4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001));
      issue(mk(1'b0, 4'b1010, 16'h8000, 16'h0013, 16'h1000, 4'b0000));
      issue(mk(1'b1, 4'b0111, 16'h1234, 16'h5678, 16'h0000, 4'b0100));
      issue(mk(1'b0, 4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100));
      wait_drain("op_sweep");

      // Hold the result for 5 cycles while the other port waits.
      stall_n = 5;
      issue(mk(1'b0, 4'b0011, 16'h1200, 16'h0034, 16'h1234, 4'b0000));
      n = 0;
      while (pq0.size() != 0 && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      v = mk(1'b1, 4'b1011, 16'h8000, 16'h0004, 16'hF800, 4'b1000);
      v.resume = 1'b1;
      issue(v);
      wait_drain("stall");
      stall_n = 0;

      // Reset while the op sits in EXEC; the result must never appear.
      v = mk(1'b0, 4'b0000, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
      v.drop = 1'b1;
      issue(v);
      n = 0;
      while (pq0.size() != 0 && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      @(negedge clk);
      #3;
      chk("exec_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_exec_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous contention straight after reset.
      start = grant_log.size();
      issue(mk(1'b0, 4'b0000, 16'h0001, 16'h0001, 16'h0002, 4'b0000));
      issue(mk(1'b0, 4'b0000, 16'h0010, 16'h0010, 16'h0020, 4'b0000));
      issue(mk(1'b0, 4'b0000, 16'h0100, 16'h0100, 16'h0200, 4'b0000));
      issue(mk(1'b0, 4'b0000, 16'h1000, 16'h1000, 16'h2000, 4'b0000));
      issue(mk(1'b1, 4'b0001, 16'h0009, 16'h0002, 16'h0007, 4'b0000));
      issue(mk(1'b1, 4'b0001, 16'h0090, 16'h0020, 16'h0070, 4'b0000));
      issue(mk(1'b1, 4'b0001, 16'h0900, 16'h0200, 16'h0700, 4'b0000));
      issue(mk(1'b1, 4'b0001, 16'h9000, 16'h2000, 16'h7000, 4'b0001));
      wait_drain("contention");
`ifdef ALU_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      for (int k = 0; k < 4; k++) begin
         if (grant_log.size() > start + k) begin
            chk($sformatf("grant_order_%0d", k), grant_log[start + k], exp_g[k]);
         end else begin
            chk($sformatf("grant_missing_%0d", k), grant_log.size(), start + k + 1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
